// File: rtl/addr_fifo_hs_pkg.sv
// Shared helpers for the output address queue: width math and parameter
// legality checks used at elaboration time.
package addr_fifo_hs_pkg;

    localparam int unsigned DEF_ADDR_WIDTH = 32'd32;
    localparam int unsigned DEF_DEPTH      = 32'd16;
    localparam int unsigned DEF_AF_LEVEL   = 32'd12;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        int unsigned v;
        res = 32'd0;
        v   = 32'd1;
        while (v < value) begin
            v   = v << 1;
            res = res + 32'd1;
        end
        return res;
    endfunction

    function automatic bit is_pow2(input int unsigned value);
        return (value != 32'd0) && ((value & (value - 32'd1)) == 32'd0);
    endfunction

    function automatic bit params_ok(input int unsigned depth, input int unsigned af_level);
        return is_pow2(depth) && (depth >= 32'd2) &&
               (af_level >= 32'd1) && (af_level <= depth);
    endfunction

endpackage

// File: rtl/addr_fifo_mem.sv
// Address storage: register array with one synchronous write port and one
// asynchronous read port. Contents are intentionally not reset.
module addr_fifo_mem
    import addr_fifo_hs_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DEPTH      = DEF_DEPTH,
    localparam int unsigned PTR_W     = clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [PTR_W-1:0]      wr_addr,
    input  logic [ADDR_WIDTH-1:0] wr_data,
    input  logic [PTR_W-1:0]      rd_addr,
    output logic [ADDR_WIDTH-1:0] rd_data
);

    logic [ADDR_WIDTH-1:0] mem_r [DEPTH];

    // Single write port; no reset so the array maps onto plain storage.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/addr_fifo_hs.sv
// First-word-fall-through address queue with valid/ready on both sides,
// occupancy/almost-full reporting, synchronous flush and sticky overflow.
module addr_fifo_hs
    import addr_fifo_hs_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DEPTH      = DEF_DEPTH,
    parameter int unsigned AF_LEVEL   = DEF_AF_LEVEL
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic [ADDR_WIDTH-1:0]        in_addr,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [ADDR_WIDTH-1:0]        out_addr,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [clog2(DEPTH+1)-1:0]    count,
    output logic                         full,
    output logic                         almost_full,
    output logic                         empty,
    output logic                         overflow
);

    localparam int unsigned PTR_W = clog2(DEPTH);
    localparam int unsigned CNT_W = clog2(DEPTH + 32'd1);

    if (!params_ok(DEPTH, AF_LEVEL)) begin : g_param_check
        $error("addr_fifo_hs: DEPTH must be a power of two >= 2 and 1 <= AF_LEVEL <= DEPTH");
    end

    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             overflow_r;
    logic             full_s;
    logic             empty_s;
    logic             push_s;
    logic             pop_s;

    // Status depends only on registered occupancy, never on the handshakes.
    assign full_s      = (count_r == CNT_W'(DEPTH));
    assign empty_s     = (count_r == {CNT_W{1'b0}});
    assign full        = full_s;
    assign empty       = empty_s;
    assign almost_full = (count_r >= CNT_W'(AF_LEVEL));
    assign in_ready    = !full_s;
    assign out_valid   = !empty_s;
    assign count       = count_r;
    assign overflow    = overflow_r;

    assign push_s = in_valid && !full_s;
    assign pop_s  = out_ready && !empty_s;

    // Pointer, occupancy and overflow state; flush overrides any handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            overflow_r <= 1'b0;
        end else if (flush) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
            if (in_valid && full_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    addr_fifo_mem #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push_s && !flush),
        .wr_addr (wr_ptr_r),
        .wr_data (in_addr),
        .rd_addr (rd_ptr_r),
        .rd_data (out_addr)
    );

endmodule

// File: tb/tb_addr_fifo_hs.sv
// Self-checking bench for addr_fifo_hs: vector table for the fill/overflow
// phase, queue reference model for everything else.
module tb_addr_fifo_hs;

    localparam int AW    = 32;
    localparam int DEPTH = 16;
    localparam int AFL   = 12;
    localparam int CW    = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic [AW-1:0] in_addr;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] out_addr;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] count;
    logic          full;
    logic          almost_full;
    logic          empty;
    logic          overflow;

    int n_checks = 0;
    int n_errors = 0;

    logic [AW-1:0] model_q[$];
    bit            model_ovf;

    typedef struct {
        logic          iv;
        logic [AW-1:0] addr;
        logic          ordy;
        int            exp_count;
        logic          exp_full;
        logic          exp_af;
        logic          exp_ovf;
        logic [AW-1:0] exp_head;
    } vec_t;

    vec_t vecs[18];

    addr_fifo_hs #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .AF_LEVEL(AFL)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_addr     (in_addr),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_addr    (out_addr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .count       (count),
        .full        (full),
        .almost_full (almost_full),
        .empty       (empty),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock edge with the model advanced by the same rules the queue obeys.
    task automatic tick();
        bit push_ok;
        bit pop_ok;
        push_ok = in_valid && (model_q.size() < DEPTH);
        pop_ok  = out_ready && (model_q.size() > 0);
        @(posedge clk);
        if (flush) begin
            model_q.delete();
            model_ovf = 1'b0;
        end else begin
            if (in_valid && !push_ok) model_ovf = 1'b1;
            if (pop_ok) void'(model_q.pop_front());
            if (push_ok) model_q.push_back(in_addr);
        end
        #1;
    endtask

    task automatic check_model(input string tag);
        int sz;
        sz = model_q.size();
        chk({tag, ".count"},     64'(count),       64'(sz));
        chk({tag, ".empty"},     64'(empty),       64'(sz == 0));
        chk({tag, ".full"},      64'(full),        64'(sz == DEPTH));
        chk({tag, ".af"},        64'(almost_full), 64'(sz >= AFL));
        chk({tag, ".in_ready"},  64'(in_ready),    64'(sz != DEPTH));
        chk({tag, ".out_valid"}, 64'(out_valid),   64'(sz != 0));
        chk({tag, ".overflow"},  64'(overflow),    64'(model_ovf));
        if (sz != 0) chk({tag, ".out_addr"}, 64'(out_addr), 64'(model_q[0]));
    endtask

    task automatic idle_inputs();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        in_addr   = 32'h0;
    endtask

    initial begin
        logic [AW-1:0] next_data;
        logic [AW-1:0] last_pop;
        int            pushes;

        // Fill phase vectors: 16 pushes, one rejected push, one idle cycle.
        for (int i = 0; i < DEPTH; i++) begin
            vecs[i] = '{1'b1, 32'h100 + 32'(i), 1'b0, i + 1,
                        (i + 1) == DEPTH, (i + 1) >= AFL, 1'b0, 32'h100};
        end
        vecs[16] = '{1'b1, 32'hDEAD, 1'b0, DEPTH, 1'b1, 1'b1, 1'b1, 32'h100};
        vecs[17] = '{1'b0, 32'h0,    1'b0, DEPTH, 1'b1, 1'b1, 1'b1, 32'h100};

        idle_inputs();
        rst = 1'b1;
        model_ovf = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.count", 64'(count), 64'd0);
        chk("rst.empty", 64'(empty), 64'd1);
        chk("rst.out_valid", 64'(out_valid), 64'd0);
        chk("rst.full", 64'(full), 64'd0);
        chk("rst.af", 64'(almost_full), 64'd0);
        chk("rst.in_ready", 64'(in_ready), 64'd1);
        chk("rst.overflow", 64'(overflow), 64'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 18; i++) begin
            in_valid  = vecs[i].iv;
            in_addr   = vecs[i].addr;
            out_ready = vecs[i].ordy;
            tick();
            chk("vec.count", 64'(count), 64'(vecs[i].exp_count));
            chk("vec.full", 64'(full), 64'(vecs[i].exp_full));
            chk("vec.in_ready", 64'(in_ready), 64'(!vecs[i].exp_full));
            chk("vec.af", 64'(almost_full), 64'(vecs[i].exp_af));
            chk("vec.overflow", 64'(overflow), 64'(vecs[i].exp_ovf));
            chk("vec.out_addr", 64'(out_addr), 64'(vecs[i].exp_head));
            check_model("vec");
        end

        // Drain: strict order, rejected 0xDEAD never shows up.
        idle_inputs();
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            chk("drain.out_addr", 64'(out_addr), 64'(32'h100 + 32'(i)));
            tick();
            check_model("drain");
        end
        chk("drain.empty", 64'(empty), 64'd1);

        // Build count=5, then push and pop together.
        idle_inputs();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_addr  = 32'h300 + 32'(i);
            tick();
        end
        in_addr   = 32'h200;
        out_ready = 1'b1;
        tick();
        chk("simul.count", 64'(count), 64'd5);
        chk("simul.head", 64'(out_addr), 64'h301);
        check_model("simul");
        in_valid = 1'b0;
        last_pop = 32'h0;
        for (int i = 0; i < DEPTH && model_q.size() > 0; i++) begin
            last_pop = out_addr;
            tick();
            check_model("simul_drain");
        end
        chk("simul.last", 64'(last_pop), 64'h200);
        chk("simul.empty", 64'(empty), 64'd1);

        // Wrap-around with random consumer stalls.
        next_data = 32'h1000;
        pushes    = 0;
        for (int i = 0; i < 40; i++) begin
            in_valid  = 1'b1;
            in_addr   = next_data;
            out_ready = ($urandom_range(3, 0) != 0);
            if (model_q.size() < DEPTH) begin
                next_data = next_data + 32'd1;
                pushes++;
            end
            tick();
            check_model("wrap");
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH + 2 && model_q.size() > 0; i++) begin
            tick();
            check_model("wrap_drain");
        end
        chk("wrap.empty", 64'(empty), 64'd1);
        chk("wrap.pushes_ge_2depth", 64'(pushes >= 2 * DEPTH), 64'd1);

        // Push into empty with consumer always ready.
        in_valid  = 1'b1;
        in_addr   = 32'h555;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("fwft.out_valid", 64'(out_valid), 64'd1);
        chk("fwft.out_addr", 64'(out_addr), 64'h555);
        tick();
        chk("fwft.empty", 64'(empty), 64'd1);
        check_model("fwft");

        // Flush at count=7 with sticky overflow and handshakes asserted.
        idle_inputs();
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            in_addr  = 32'h700 + 32'(i);
            tick();
        end
        chk("preflush.count", 64'(count), 64'd7);
        chk("preflush.overflow", 64'(overflow), 64'd1);
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_addr   = 32'hBEEF;
        out_ready = 1'b1;
        tick();
        chk("flush.count", 64'(count), 64'd0);
        chk("flush.empty", 64'(empty), 64'd1);
        chk("flush.overflow", 64'(overflow), 64'd0);
        idle_inputs();
        in_valid = 1'b1;
        in_addr  = 32'hCAFE;
        tick();
        in_valid = 1'b0;
        chk("postflush.count", 64'(count), 64'd1);
        chk("postflush.head", 64'(out_addr), 64'hCAFE);
        check_model("postflush");

        // Async reset mid-fill: outputs clear without a clock edge.
        in_valid = 1'b1;
        in_addr  = 32'h900;
        tick();
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        model_q.delete();
        model_ovf = 1'b0;
        chk("arst.count", 64'(count), 64'd0);
        chk("arst.out_valid", 64'(out_valid), 64'd0);
        chk("arst.empty", 64'(empty), 64'd1);
        chk("arst.in_ready", 64'(in_ready), 64'd1);
        #1;
        rst = 1'b0;
        tick();
        check_model("after_arst");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/addr_fifo_hs.md
Name: addr_fifo_hs

Overview:
Parametrised successor to the output address queue used between the convolution address generator and the output write stage. Stores output addresses in a power-of-two circular buffer with a first-word-fall-through valid/ready interface on both sides. Adds the following over the previous queue:
- Correct simultaneous push/pop.
- Full, almost-full and occupancy reporting.
- Synchronous flush.
- A sticky overflow flag.

Parameters:
ADDR_WIDTH, 32, width of each stored address.
DEPTH, 16, number of entries; must be a power of two and at least 2.
AF_LEVEL, 12, occupancy at or above which almost_full asserts; 1 <= AF_LEVEL <= DEPTH.

Ports:
clk  in  1  rising-edge clock.
rst  in  1  asynchronous active-high reset.
flush  in  1  synchronous clear of contents and overflow flag.
in_addr  in  ADDR_WIDTH  address to enqueue.
in_valid  in  1  producer has in_addr.
in_ready  out  1  queue can accept; equals !full.
out_addr  out  ADDR_WIDTH  head-of-queue address (FWFT).
out_valid  out  1  head entry valid; equals !empty.
out_ready  in  1  consumer takes head this cycle.
count  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.
full  out  1  count == DEPTH.
almost_full  out  1  count >= AF_LEVEL.
empty  out  1  count == 0.
overflow  out  1  sticky: a push was attempted while full.

Behaviour:
- Reset (async, rst=1):
  - wr_ptr, rd_ptr and count go to 0.
  - overflow=0, empty=1, out_valid=0, full=0, almost_full=0, in_ready=1.
  - Storage contents are not reset.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. count is one bit wider than the pointers so DEPTH is representable.
- Push accepted when in_valid && in_ready, with in_ready based on the registered count only:
  - Stores in_addr at wr_ptr.
  - wr_ptr increments.
- Pop accepted when out_valid && out_ready, with out_valid = !empty:
  - rd_ptr increments.
- FWFT output:
  - out_addr = mem[rd_ptr], combinational read of registered state.
  - Write-to-out latency is 1 cycle: an entry pushed into an empty queue at edge N appears with out_valid=1 after edge N.
  - out_addr is don't-care while out_valid=0. The bench must not check it then.
- Count update:
  - push only: +1.
  - pop only: -1.
  - both, or neither: unchanged.
- Simultaneous push and pop:
  - When full, push is rejected because in_ready=0. The pop still proceeds, leaving count = DEPTH-1.
  - When empty, pop is impossible because out_valid=0. The push proceeds, leaving count = 1.
- Overflow:
  - In any cycle with in_valid && !in_ready && !flush, overflow <= 1.
  - overflow stays set until flush or rst.
  - The rejected data is not stored.
- Flush (synchronous, highest priority after rst):
  - At the clock edge: pointers=0, count=0, overflow=0.
  - Any push or pop in the same cycle is ignored.
- Status outputs (full, almost_full, empty, in_ready, out_valid) are decoded from the registered count. They never combinationally depend on in_valid or out_ready.
- Storage is a plain register array with one write port and one async read port. No reset on the array.
- Mid-operation reset: async reset clears everything immediately. Entries present before reset are lost, and out_valid drops without waiting for a clock.

Decomposition:
- Shared package:
  - Function clog2.
  - Localparams PTR_W = clog2(DEPTH) and CNT_W = clog2(DEPTH+1).
  - An elaboration-time check that DEPTH is a power of two and that AF_LEVEL is in range.
- One natural sub-module: addr_fifo_mem, parametrised by ADDR_WIDTH and DEPTH, with a write-enable/address/data port and an async read-address/data port.
- Pointer/count/flag control stays in addr_fifo_hs.

Test Plan:
- Reset then fill: 16 back-to-back pushes of 0x100..0x10F with out_ready=0.
  - count counts 1..16.
  - almost_full rises when count reaches 12.
  - full=1 and in_ready=0 after the 16th push.
  - out_addr=0x100 throughout.
- Overflow: while full, assert in_valid with 0xDEAD for 1 cycle.
  - overflow=1 and count stays 16.
  - Draining gives 0x100..0x10F in order and never 0xDEAD; empty=1 at the end.
- Simultaneous push/pop at count=5 with in_addr=0x200:
  - count stays 5.
  - Head advances.
  - 0x200 is the last entry drained.
- Wrap-around: 40 push/pop cycles with random out_ready stalls and incrementing data.
  - Output order matches input order exactly.
  - Pointers wrap at least twice.
- Push into empty with out_ready=1 held:
  - out_valid=1 one cycle after the push, with out_addr=pushed value.
  - The pop occurs that cycle and empty=1 the next cycle.
- Flush with count=7 and overflow=1, with push and pop asserted in the same cycle:
  - After the edge: count=0, empty=1, overflow=0.
  - The flushed-cycle push is not stored.
  - An async rst pulse mid-fill clears everything without a clock edge.
